led_pattern_ctrl: RTL

Board-level LED sequencer for the Zybo Z7-20 user LEDs.
- Synchronises and debounces the four slide switches.
- sw[1:0] selects a display pattern (off / blink / chase / bounce); sw[3:2] selects step speed.
- Drives the 4-bit LED bank from a prescaled step tick.
- Sits between the board switch pins and the LED pins, replacing direct sw-to-led wiring.

---
 rtl/led_pattern_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// LED sequencer: synchronises and debounces the slide switches, then steps one
// of four LED patterns (off/blink/chase/bounce) at a switch-selected speed.
module led_pattern_ctrl #(
  parameter int unsigned TICK_DIV   = 12500000,
  parameter int unsigned DEB_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       step_tick
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       sw_prev_q, sw_prev_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       sw_db_q, sw_db_d;
  mode_e            mode_q, mode_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       step_cnt_q, step_cnt_d;
  logic             step_tick_q, step_tick_d;
  logic [3:0]       led_q, led_d;
  dir_e             dir_q, dir_d;

  logic             base_tick_c;
  mode_e            mode_sel_c;
  logic [1:0]       speed_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_prev_q   <= '0;
      deb_cnt_q   <= '0;
      sw_db_q     <= '0;
      mode_q      <= MODE_OFF;
      pre_cnt_q   <= '0;
      step_cnt_q  <= '0;
      step_tick_q <= 1'b0;
      led_q       <= '0;
      dir_q       <= DIR_LEFT;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_prev_q   <= sw_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      sw_db_q     <= sw_db_d;
      mode_q      <= mode_d;
      pre_cnt_q   <= pre_cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_tick_q <= step_tick_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
    end
  end

  assign base_tick_c = (pre_cnt_q == PRE_LAST);
  assign mode_sel_c  = mode_e'(sw_db_q[1:0]);
  assign speed_c     = sw_db_q[3:2];

  // Next-state: sync, debounce, prescaler, pattern stepping, mode reload
  always_comb begin
    sync1_d     = sw;
    sync2_d     = sync1_q;
    sw_prev_d   = sync2_q;
    deb_cnt_d   = '0;
    sw_db_d     = sw_db_q;
    mode_d      = mode_q;
    pre_cnt_d   = base_tick_c ? '0 : pre_cnt_q + PRE_W'(1);
    step_cnt_d  = step_cnt_q;
    step_tick_d = 1'b0;
    led_d       = led_q;
    dir_d       = dir_q;

    if ((sync2_q != sw_db_q) && (sync2_q == sw_prev_q)) begin
      if (deb_cnt_q == DEB_LAST) begin
        sw_db_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    if (base_tick_c) begin
      if (step_cnt_q >= speed_c) begin
        step_tick_d = 1'b1;
        step_cnt_d  = '0;
      end else begin
        step_cnt_d = step_cnt_q + 2'd1;
      end
    end

    if (step_tick_q) begin
      case (mode_q)
        MODE_BLINK: led_d = ~led_q;
        MODE_CHASE: led_d = {led_q[2:0], led_q[3]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            led_d = {led_q[2:0], 1'b0};
            if (led_q[2]) dir_d = DIR_RIGHT;
          end else begin
            led_d = {1'b0, led_q[3:1]};
            if (led_q[1]) dir_d = DIR_LEFT;
          end
        end
        default: led_d = 4'b0000;
      endcase
    end

    // A new mode wins over any step in flight and restarts the timebase
    if (mode_sel_c != mode_q) begin
      mode_d      = mode_sel_c;
      pre_cnt_d   = '0;
      step_cnt_d  = '0;
      step_tick_d = 1'b0;
      dir_d       = DIR_LEFT;
      case (mode_sel_c)
        MODE_BLINK:  led_d = 4'b1111;
        MODE_CHASE:  led_d = 4'b0001;
        MODE_BOUNCE: led_d = 4'b0001;
        default:     led_d = 4'b0000;
      endcase
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign step_tick = step_tick_q;

endmodule
